// File: rtl/audio_frame_timing.sv
// audio_frame_timing: fractional-rate sample tick plus BCLK, frame sync and shifter
// strobes for I2S/TDM framing. Define AUDIO_TIMING_MCLK_EN to build the free-running MCLK divider.
module audio_frame_timing #(
  parameter int CLK_RATE   = 24576000,
  parameter int AUDIO_RATE = 48000,
  parameter int SLOT_BITS  = 16,
  parameter int NUM_SLOTS  = 2,
  parameter int FS_MODE    = 0,
  parameter int MCLK_DIV   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  output logic                         sample_ce,
  output logic                         bclk,
  output logic                         fsync,
  output logic                         load_strobe,
  output logic                         shift_strobe,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
  output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
  output logic                         mclk,
  output logic                         fsm_state
);

  localparam int P        = CLK_RATE / AUDIO_RATE;
  localparam int HALF_DIV = P / (2 * SLOT_BITS * NUM_SLOTS);
  localparam int ACC_W    = $clog2(CLK_RATE + AUDIO_RATE);
  localparam int DIV_W    = (HALF_DIV < 2) ? 1 : $clog2(HALF_DIV);
  localparam int SLOT_W   = $clog2(NUM_SLOTS);
  localparam int BIT_W    = $clog2(SLOT_BITS);

  localparam logic [ACC_W-1:0]  AUDIO_INC  = ACC_W'(AUDIO_RATE);
  localparam logic [ACC_W-1:0]  CLK_MOD    = ACC_W'(CLK_RATE);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(HALF_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_W-1:0] HALF_SLOTS = SLOT_W'(NUM_SLOTS / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(SLOT_BITS - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  generate
    if (HALF_DIV < 1) begin : g_bad_ratio
      $error("audio_frame_timing: CLK_RATE/AUDIO_RATE too small for SLOT_BITS*NUM_SLOTS");
    end
    if (SLOT_BITS < 8 || SLOT_BITS > 32) begin : g_bad_slot_bits
      $error("audio_frame_timing: SLOT_BITS must be 8..32");
    end
    if (NUM_SLOTS < 2 || NUM_SLOTS > 16 || (NUM_SLOTS % 2) != 0) begin : g_bad_num_slots
      $error("audio_frame_timing: NUM_SLOTS must be even, 2..16");
    end
    if (MCLK_DIV < 1) begin : g_bad_mclk_div
      $error("audio_frame_timing: MCLK_DIV must be at least 1");
    end
  endgenerate

  // Phase accumulator: never stops, so sample_ce keeps exact average rate.
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             wrap;

  always_comb begin
    acc_sum = acc + AUDIO_INC;
    wrap    = (acc_sum >= CLK_MOD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      sample_ce <= 1'b0;
    end else begin
      acc       <= wrap ? (acc_sum - CLK_MOD) : acc_sum;
      sample_ce <= wrap;
    end
  end

  logic [0:0]        state;
  logic [DIV_W-1:0]  div;
  logic              lr_q;
  logic              fs_pulse_q;
  logic              frame_go;
  logic              stepping;
  logic              half_done;
  logic              falling;
  logic [SLOT_W-1:0] slot_nxt;
  logic [BIT_W-1:0]  bit_nxt;
  logic              frame_last;

  // The load cycle is the first clock of the frame, so a frame of F clocks
  // ends exactly when the next sample_ce can arrive (no idle gap when F == P).
  always_comb begin
    frame_go   = (state == ST_IDLE) && sample_ce && enable;
    stepping   = (state == ST_FRAME) || frame_go;
    half_done  = (div == DIV_LAST);
    falling    = (state == ST_FRAME) && half_done && bclk;
    frame_last = (bit_idx == BIT_LAST) && (slot_idx == SLOT_LAST);
    bit_nxt    = bit_idx + BIT_W'(1);
    slot_nxt   = slot_idx;
    if (bit_idx == BIT_LAST) begin
      bit_nxt  = '0;
      slot_nxt = (slot_idx == SLOT_LAST) ? '0 : (slot_idx + SLOT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      div          <= '0;
      bclk         <= 1'b0;
      shift_strobe <= 1'b0;
      slot_idx     <= '0;
      bit_idx      <= '0;
      lr_q         <= 1'b0;
      fs_pulse_q   <= 1'b0;
    end else begin
      shift_strobe <= 1'b0;
      if (frame_go) begin
        state      <= ST_FRAME;
        fs_pulse_q <= 1'b1;
        slot_idx   <= '0;
        bit_idx    <= '0;
      end
      if (stepping) begin
        if (half_done) begin
          div  <= '0;
          bclk <= ~bclk;
        end else begin
          div <= div + DIV_W'(1);
        end
      end
      if (falling) begin
        shift_strobe <= 1'b1;
        fs_pulse_q   <= 1'b0;
        bit_idx      <= bit_nxt;
        slot_idx     <= slot_nxt;
        lr_q         <= (slot_nxt >= HALF_SLOTS);
        if (frame_last) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  assign load_strobe = frame_go;
  assign fsm_state   = state;
  // FS_MODE 1 pulse covers the load cycle plus the rest of the first BCLK period.
  assign fsync       = (FS_MODE == 0) ? lr_q : (load_strobe | fs_pulse_q);

`ifdef AUDIO_TIMING_MCLK_EN
  localparam int MCLK_W = (MCLK_DIV < 2) ? 1 : $clog2(MCLK_DIV);
  localparam logic [MCLK_W-1:0] MCLK_LAST = MCLK_W'(MCLK_DIV - 1);
  logic [MCLK_W-1:0] mclk_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mclk_cnt <= '0;
      mclk     <= 1'b0;
    end else if (mclk_cnt == MCLK_LAST) begin
      mclk_cnt <= '0;
      mclk     <= ~mclk;
    end else begin
      mclk_cnt <= mclk_cnt + MCLK_W'(1);
    end
  end
`else
  assign mclk = 1'b0;
`endif

`ifndef SYNTHESIS
  a_no_ce_in_frame: assert property (@(posedge clk) disable iff (reset)
    !(sample_ce && (state == ST_FRAME)))
    else $error("audio_frame_timing: sample_ce arrived while a frame was active");
`endif

endmodule

// File: tb/tb_audio_frame_timing.sv
// Directed bench for audio_frame_timing: three configurations (16x2 I2S, 25 MHz
// fractional ratio, 32x8 TDM pulse) checked against hand-computed cycle positions.
module tb_audio_frame_timing;

  logic clk = 1'b0;
  logic reset;
  logic enable_a, enable_b, enable_c;

  always #5 clk = ~clk;

  logic       sce_a, bclk_a, fsync_a, load_a, shift_a, mclk_a, st_a;
  logic [0:0] slot_a;
  logic [3:0] bit_a;
  logic       sce_b, bclk_b, fsync_b, load_b, shift_b, mclk_b, st_b;
  logic [0:0] slot_b;
  logic [3:0] bit_b;
  logic       sce_c, bclk_c, fsync_c, load_c, shift_c, mclk_c, st_c;
  logic [2:0] slot_c;
  logic [4:0] bit_c;

  audio_frame_timing #(.CLK_RATE(24576000), .AUDIO_RATE(48000), .SLOT_BITS(16),
                       .NUM_SLOTS(2), .FS_MODE(0), .MCLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .sample_ce(sce_a), .bclk(bclk_a),
    .fsync(fsync_a), .load_strobe(load_a), .shift_strobe(shift_a), .slot_idx(slot_a),
    .bit_idx(bit_a), .mclk(mclk_a), .fsm_state(st_a));

  audio_frame_timing #(.CLK_RATE(25000000), .AUDIO_RATE(48000), .SLOT_BITS(16),
                       .NUM_SLOTS(2), .FS_MODE(0), .MCLK_DIV(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .sample_ce(sce_b), .bclk(bclk_b),
    .fsync(fsync_b), .load_strobe(load_b), .shift_strobe(shift_b), .slot_idx(slot_b),
    .bit_idx(bit_b), .mclk(mclk_b), .fsm_state(st_b));

  audio_frame_timing #(.CLK_RATE(24576000), .AUDIO_RATE(48000), .SLOT_BITS(32),
                       .NUM_SLOTS(8), .FS_MODE(1), .MCLK_DIV(2)) dut_c (
    .clk(clk), .reset(reset), .enable(enable_c), .sample_ce(sce_c), .bclk(bclk_c),
    .fsync(fsync_c), .load_strobe(load_c), .shift_strobe(shift_c), .slot_idx(slot_c),
    .bit_idx(bit_c), .mclk(mclk_c), .fsm_state(st_c));

`ifdef AUDIO_TIMING_MCLK_EN
  localparam int MCLK_HI_512  = 256;
  localparam int MCLK_HI_1024 = 512;
`else
  localparam int MCLK_HI_512  = 0;
  localparam int MCLK_HI_1024 = 0;
`endif

  localparam int R_SCE = 0, R_LOAD = 1, R_BCLK = 2, R_SHIFT = 3, R_FSYNC = 4, R_SLOT = 5;
  localparam int R_BIT = 6, R_STATE = 7, R_MCLK = 8, R_FSYNC_C = 9, R_SHIFT_C = 10;
  localparam int R_SLOT_C = 11, R_BIT_C = 12, NSIG = 13, TMAX = 1100;

  logic [31:0] rec [NSIG][TMAX+1];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input int t);
    rec[R_SCE][t]     = 32'(sce_a);
    rec[R_LOAD][t]    = 32'(load_a);
    rec[R_BCLK][t]    = 32'(bclk_a);
    rec[R_SHIFT][t]   = 32'(shift_a);
    rec[R_FSYNC][t]   = 32'(fsync_a);
    rec[R_SLOT][t]    = 32'(slot_a);
    rec[R_BIT][t]     = 32'(bit_a);
    rec[R_STATE][t]   = 32'(st_a);
    rec[R_MCLK][t]    = 32'(mclk_a);
    rec[R_FSYNC_C][t] = 32'(fsync_c);
    rec[R_SHIFT_C][t] = 32'(shift_c);
    rec[R_SLOT_C][t]  = 32'(slot_c);
    rec[R_BIT_C][t]   = 32'(bit_c);
  endtask

  // Records n cycles after the current one; index 0 is the current cycle.
  task automatic walk(input int n, input int drop_at, input int reen_at);
    snap(0);
    for (int t = 1; t <= n; t++) begin
      tick();
      snap(t);
      if (t == drop_at) enable_a = 1'b0;
      if (t == reen_at) enable_a = 1'b1;
    end
  endtask

  function automatic int count_on(input int sig, input int lo, input int hi);
    int c = 0;
    for (int t = lo; t <= hi; t++) if (rec[sig][t] != 0) c++;
    return c;
  endfunction

  task automatic wait_ce_a(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sce_a !== 1'b1 && n < budget);
  endtask

  task automatic wait_ce_b(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sce_b !== 1'b1 && n < budget);
  endtask

  int n, c, span, n520, n521, idle_hi, strobes_b, bhi1, hi;

  initial begin
    // ---- reset state
    reset = 1'b1;
    enable_a = 1'b1;
    enable_b = 1'b1;
    enable_c = 1'b1;
    tick();
    tick();
    check("rst_sample_ce", 32'(sce_a), 32'd0);
    check("rst_bclk", 32'(bclk_a), 32'd0);
    check("rst_fsync", 32'(fsync_a), 32'd0);
    check("rst_load", 32'(load_a), 32'd0);
    check("rst_shift", 32'(shift_a), 32'd0);
    check("rst_slot", 32'(slot_a), 32'd0);
    check("rst_bit", 32'(bit_a), 32'd0);
    check("rst_mclk", 32'(mclk_a), 32'd0);
    check("rst_state", 32'(st_a), 32'd0);
    check("rst_fsync_c", 32'(fsync_c), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---- first frame: 24.576 MHz / 48k, 16x2 LRCLK, and 32x8 pulse mode on C
    wait_ce_a(2000, n);
    check("a_first_ce_latency", 32'(n), 32'd512);
    walk(512, -1, -1);
    check("a_load_at_ce", rec[R_LOAD][0], 32'd1);
    check("a_bclk_t7", rec[R_BCLK][7], 32'd0);
    check("a_bclk_rise_t8", rec[R_BCLK][8], 32'd1);
    check("a_bclk_fall_t16", rec[R_BCLK][16], 32'd0);
    check("a_shift_t16", rec[R_SHIFT][16], 32'd1);
    check("a_bit_t15", rec[R_BIT][15], 32'd0);
    check("a_bit_t16", rec[R_BIT][16], 32'd1);
    check("a_state_t1", rec[R_STATE][1], 32'd1);
    check("a_lrclk_t255", rec[R_FSYNC][255], 32'd0);
    check("a_lrclk_t256", rec[R_FSYNC][256], 32'd1);
    check("a_slot_t256", rec[R_SLOT][256], 32'd1);
    check("a_lrclk_high_count", 32'(count_on(R_FSYNC, 0, 511)), 32'd256);
    check("a_strobes_frame", 32'(count_on(R_SHIFT, 1, 512)), 32'd32);
    check("a_bclk_high_count", 32'(count_on(R_BCLK, 1, 512)), 32'd256);
    check("a_no_ce_inside", 32'(count_on(R_SCE, 1, 511)), 32'd0);
    check("a_ce_period_512", rec[R_SCE][512], 32'd1);
    check("a_load_back_to_back", rec[R_LOAD][512], 32'd1);
    check("a_lrclk_t512", rec[R_FSYNC][512], 32'd0);
    check("a_slot_t512", rec[R_SLOT][512], 32'd0);
    check("a_state_t512", rec[R_STATE][512], 32'd0);
    check("a_mclk_window", 32'(count_on(R_MCLK, 1, 512)), 32'(MCLK_HI_512));
    check("c_fsync_t0", rec[R_FSYNC_C][0], 32'd1);
    check("c_fsync_t1", rec[R_FSYNC_C][1], 32'd1);
    check("c_fsync_t2", rec[R_FSYNC_C][2], 32'd0);
    check("c_fsync_high_count", 32'(count_on(R_FSYNC_C, 0, 511)), 32'd2);
    check("c_strobes_frame", 32'(count_on(R_SHIFT_C, 1, 512)), 32'd256);
    check("c_slot_t63", rec[R_SLOT_C][63], 32'd0);
    check("c_slot_t64", rec[R_SLOT_C][64], 32'd1);
    check("c_slot_t511", rec[R_SLOT_C][511], 32'd7);
    check("c_bit_t511", rec[R_BIT_C][511], 32'd31);
    check("c_slot_t512", rec[R_SLOT_C][512], 32'd0);

    // ---- enable dropped at clk 100 of a frame, re-enabled in the idle period
    walk(1040, 100, 600);
    check("en_strobes_complete", 32'(count_on(R_SHIFT, 1, 512)), 32'd32);
    check("en_ce_t512", rec[R_SCE][512], 32'd1);
    check("en_no_load_t512", rec[R_LOAD][512], 32'd0);
    check("en_bclk_idle", 32'(count_on(R_BCLK, 513, 1023)), 32'd0);
    check("en_no_strobes_idle", 32'(count_on(R_SHIFT, 513, 1023)), 32'd0);
    check("en_ce_t1024", rec[R_SCE][1024], 32'd1);
    check("en_reload_t1024", rec[R_LOAD][1024], 32'd1);
    check("en_bclk_t1032", rec[R_BCLK][1032], 32'd1);
    check("en_mclk_window", 32'(count_on(R_MCLK, 1, 1024)), 32'(MCLK_HI_1024));

    // ---- 25 MHz / 48k: fractional periods, 48 periods span 25000 clocks
    wait_ce_b(2000, n);
    check("b_first_ce_seen", 32'(sce_b), 32'd1);
    span = 0; n520 = 0; n521 = 0; idle_hi = 0; strobes_b = 0; bhi1 = 0;
    for (int k = 0; k < 48; k++) begin
      c = 0;
      do begin
        tick();
        c++;
        if (shift_b === 1'b1) strobes_b++;
        if (c > 512 && bclk_b !== 1'b0) idle_hi++;
        if (k == 0 && bclk_b === 1'b1) bhi1++;
      end while (sce_b !== 1'b1 && c < 600);
      span += c;
      if (c == 520) n520++;
      else if (c == 521) n521++;
    end
    check("b_span_48", 32'(span), 32'd25000);
    check("b_periods_521", 32'(n521), 32'd40);
    check("b_periods_520", 32'(n520), 32'd8);
    check("b_strobes_total", 32'(strobes_b), 32'd1536);
    check("b_bclk_low_idle", 32'(idle_hi), 32'd0);
    check("b_bclk_high_frame", 32'(bhi1), 32'd256);

    // ---- reset pulsed mid-frame
    wait_ce_a(1200, n);
    check("r_ce_before", 32'(sce_a), 32'd1);
    repeat (100) tick();
    check("r_bit_mid", 32'(bit_a), 32'd6);
    check("r_state_mid", 32'(st_a), 32'd1);
    check("r_shift_c_mid", 32'(shift_c), 32'd1);
    check("r_bit_c_mid", 32'(bit_c), 32'd18);
    check("r_slot_c_mid", 32'(slot_c), 32'd1);
    reset = 1'b1;
    #1;
    check("r_bit_async", 32'(bit_a), 32'd0);
    check("r_state_async", 32'(st_a), 32'd0);
    check("r_shift_c_async", 32'(shift_c), 32'd0);
    check("r_slot_c_async", 32'(slot_c), 32'd0);
    tick();
    check("r_sce_held", 32'(sce_a), 32'd0);
    check("r_bclk_held", 32'(bclk_a), 32'd0);
    check("r_fsync_c_held", 32'(fsync_c), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    hi = 0;
    do begin
      tick();
      n++;
      if (bclk_a !== 1'b0) hi++;
    end while (sce_a !== 1'b1 && n < 2000);
    check("r_first_ce_latency", 32'(n), 32'd512);
    check("r_load_with_ce", 32'(load_a), 32'd1);
    check("r_no_partial_frame", 32'(hi), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
